// File: rtl/adapter_ppfifo_2_axi_stream_wl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// adapter_ppfifo_2_axi_stream_wl
//
// Drains whole blocks from the read side of a Ping Pong FIFO and presents
// them as an AXI Stream master. The PPFIFO data arrives one cycle after each
// strobe. A two-entry output buffer with credit-based strobing absorbs that
// latency, so downstream backpressure never loses a word. While the consumer
// keeps ready high, one word leaves per clock.
//
// Handshake semantics (both sides):
//   AXI: a beat transfers on any rising edge where o_axi_valid && i_axi_ready.
//        Once o_axi_valid is high, it stays high and o_axi_data/o_axi_last
//        stay stable until that transfer. o_axi_valid is a pure register
//        decode and never depends combinationally on i_axi_ready.
//   PPFIFO: o_ppfifo_stb pops one word. That word is on i_ppfifo_data during
//        the next cycle. A strobe is only issued when the buffer is sure to
//        have room for the word: occupancy + in-flight - this-cycle pop < 2.
//
// Ports
//   i_axi_clk      sole clock, forwarded on o_ppfifo_clk
//   rst_n          asynchronous active-low reset
//   i_ppfifo_rdy   a filled block is available
//   o_ppfifo_act   block owned by this adapter (high from WAIT to RELEASE)
//   i_ppfifo_size  word count of the block, latched on activation
//   o_ppfifo_stb   pop one word (combinational)
//   i_ppfifo_data  read word, top bit is the sideband last flag
//   o_axi_valid / i_axi_ready / o_axi_data / o_axi_keep / o_axi_last
//                  AXI Stream master; keep is always all ones
//   dbg_state      current FSM state, for checkers
// ---------------------------------------------------------------------------
module adapter_ppfifo_2_axi_stream_wl #(
   parameter int DATA_WIDTH    = 32,
   parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
   parameter bit LAST_ON_BLOCK = 1'b1,
   parameter bit USE_DATA_LAST = 1'b0
) (
   input  logic                    i_axi_clk,
   input  logic                    rst_n,
   output logic                    o_ppfifo_clk,
   input  logic                    i_ppfifo_rdy,
   output logic                    o_ppfifo_act,
   input  logic [23:0]             i_ppfifo_size,
   output logic                    o_ppfifo_stb,
   input  logic [DATA_WIDTH:0]     i_ppfifo_data,
   output logic                    o_axi_valid,
   input  logic                    i_axi_ready,
   output logic [DATA_WIDTH-1:0]   o_axi_data,
   output logic [STROBE_WIDTH-1:0] o_axi_keep,
   output logic                    o_axi_last,
   output logic [2:0]              dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_READ    = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [23:0]           r_size;
   logic [23:0]           r_count;
   logic                  inflight;       // strobe issued last cycle
   logic                  inflight_last;  // that strobe addressed the final index
   logic [1:0]            occ;
   logic [DATA_WIDTH-1:0] buf0_data;      // head entry
   logic [DATA_WIDTH-1:0] buf1_data;
   logic                  buf0_last;
   logic                  buf1_last;
   logic                  pop;
   logic                  stb;
   logic                  room;
   logic                  wr_last;
   logic [2:0]            pending;
   logic [23:0]           count_next;

   assign o_ppfifo_clk = i_axi_clk;
   assign o_axi_keep   = '1;
   assign o_ppfifo_act = (state_q != ST_IDLE);
   assign o_axi_valid  = (occ != 2'd0);
   assign o_axi_data   = buf0_data;
   assign o_axi_last   = buf0_last;
   assign dbg_state    = state_q;

   assign pop     = o_axi_valid & i_axi_ready;
   // Words already committed to the buffer: stored plus the one in flight.
   // A pop this cycle frees a slot before the strobed word can land.
   assign pending = {1'b0, occ} + {2'b00, inflight};
   assign room    = pending < (3'd2 + {2'b00, pop});
   assign stb     = (state_q == ST_READ) && (r_count < r_size) && room;
   assign o_ppfifo_stb = stb;

   assign count_next = r_count + {23'd0, stb};
   assign wr_last    = (LAST_ON_BLOCK && inflight_last) ||
                       (USE_DATA_LAST && i_ppfifo_data[DATA_WIDTH]);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (i_ppfifo_rdy) state_d = ST_WAIT;
         ST_WAIT:    state_d = (r_size != 24'd0) ? ST_READ : ST_RELEASE;
         ST_READ:    if (count_next == r_size) state_d = ST_DRAIN;
         ST_DRAIN:   if (!inflight && (occ == 2'd0)) state_d = ST_RELEASE;
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // State, block counters and strobe pipeline
   always_ff @(posedge i_axi_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         r_size        <= '0;
         r_count       <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         state_q  <= state_d;
         inflight <= stb;
         // r_size > 0 whenever stb is high, so r_size - 1 cannot wrap here.
         inflight_last <= stb && (r_count == (r_size - 24'd1));
         if ((state_q == ST_IDLE) && i_ppfifo_rdy) begin
            r_size  <= i_ppfifo_size;
            r_count <= '0;
         end else if (stb) begin
            r_count <= r_count + 24'd1;
         end
      end
   end

   // Two-entry output buffer; entry 0 is always the head presented on AXI.
   always_ff @(posedge i_axi_clk or negedge rst_n) begin
      if (!rst_n) begin
         occ       <= 2'd0;
         buf0_data <= '0;
         buf1_data <= '0;
         buf0_last <= 1'b0;
         buf1_last <= 1'b0;
      end else begin
         case ({inflight, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  buf0_data <= i_ppfifo_data[DATA_WIDTH-1:0];
                  buf0_last <= wr_last;
               end else begin
                  buf1_data <= i_ppfifo_data[DATA_WIDTH-1:0];
                  buf1_last <= wr_last;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               buf0_data <= buf1_data;
               buf0_last <= buf1_last;
               occ       <= occ - 2'd1;
            end
            2'b11: begin
               // Pop and write together: occupancy is unchanged.
               if (occ == 2'd1) begin
                  buf0_data <= i_ppfifo_data[DATA_WIDTH-1:0];
                  buf0_last <= wr_last;
               end else begin
                  buf0_data <= buf1_data;
                  buf0_last <= buf1_last;
                  buf1_data <= i_ppfifo_data[DATA_WIDTH-1:0];
                  buf1_last <= wr_last;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adapter_ppfifo_2_axi_stream_wl.sv
`timescale 1ns/1ps
// Bench for adapter_ppfifo_2_axi_stream_wl. Two instances share one PPFIFO
// model: u_dut marks block ends, u_dut_sb marks only the sideband bit.
module tb_adapter_ppfifo_2_axi_stream_wl;

   localparam int DW = 32;
   localparam int W  = DW + 2;   // {block_end_last, sideband_last, data}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic              ppfifo_rdy;
   logic [23:0]       size;
   logic [DW:0]       ppfifo_data;
   logic              ready;

   logic              ppfifo_clk, act, stb, valid, last;
   logic [DW-1:0]     data;
   logic [DW/8-1:0]   keep;
   logic [2:0]        dbg_state;
   logic              ppfifo_clk2, act2, stb2, valid2, last2;
   logic [DW-1:0]     data2;
   logic [DW/8-1:0]   keep2;
   logic [2:0]        dbg_state2;

   adapter_ppfifo_2_axi_stream_wl #(
      .DATA_WIDTH(DW), .LAST_ON_BLOCK(1'b1), .USE_DATA_LAST(1'b0)
   ) u_dut (
      .i_axi_clk(clk), .rst_n(rst_n), .o_ppfifo_clk(ppfifo_clk),
      .i_ppfifo_rdy(ppfifo_rdy), .o_ppfifo_act(act), .i_ppfifo_size(size),
      .o_ppfifo_stb(stb), .i_ppfifo_data(ppfifo_data), .o_axi_valid(valid),
      .i_axi_ready(ready), .o_axi_data(data), .o_axi_keep(keep),
      .o_axi_last(last), .dbg_state(dbg_state)
   );

   adapter_ppfifo_2_axi_stream_wl #(
      .DATA_WIDTH(DW), .LAST_ON_BLOCK(1'b0), .USE_DATA_LAST(1'b1)
   ) u_dut_sb (
      .i_axi_clk(clk), .rst_n(rst_n), .o_ppfifo_clk(ppfifo_clk2),
      .i_ppfifo_rdy(ppfifo_rdy), .o_ppfifo_act(act2), .i_ppfifo_size(size),
      .o_ppfifo_stb(stb2), .i_ppfifo_data(ppfifo_data), .o_axi_valid(valid2),
      .i_axi_ready(ready), .o_axi_data(data2), .o_axi_keep(keep2),
      .o_axi_last(last2), .dbg_state(dbg_state2)
   );

   // ---------------- PPFIFO read-side model ----------------
   logic [DW:0] mem [0:1023];
   int          blk_start = 0;
   int          wr_ptr = 0;
   int          rd_ptr = 0;

   always @(posedge clk) begin
      if (!act) rd_ptr <= blk_start;
      else if (stb) rd_ptr <= rd_ptr + 1;
      if (stb) ppfifo_data <= mem[rd_ptr[9:0]];
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin : monitor
      int           out_cnt;
      logic         pv;
      logic [DW-1:0] pd;
      logic         pl;
      logic         pop;
      logic [W-1:0] e;
      out_cnt = 0;
      pv = 1'b0;
      pd = '0;
      pl = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            out_cnt = 0;
            pv = 1'b0;
         end else begin
            pop = valid && ready;
            if (pv) begin
               check("hold_valid", valid, 1);
               check("hold_data", data, pd);
               check("hold_last", last, pl);
            end
            if (stb) begin
               check("stb_credit", ((out_cnt - (pop ? 1 : 0)) < 2), 1);
               check("stb_act", act, 1);
            end
            check("dut2_stb", stb2, stb);
            check("dut2_valid", valid2, valid);
            check("dut2_act", act2, act);
            if (pop) begin
               check("beat_expected", (exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("beat_data", data, e[DW-1:0]);
                  check("beat_last", last, e[DW+1]);
                  check("beat_last_sb", last2, e[DW]);
                  check("dut2_data", data2, e[DW-1:0]);
               end
            end
            out_cnt = out_cnt + (stb ? 1 : 0) - (pop ? 1 : 0);
            pv = valid && !ready;
            pd = data;
            pl = last;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   // Loads one block into the PPFIFO model and queues the expected beats.
   task automatic load_block(input int n, input int side_pos, input bit fixed,
                             input logic [DW-1:0] base, input bit rand_side);
      logic [DW-1:0] d;
      logic          sb;
      blk_start = wr_ptr;
      size = n[23:0];
      for (int i = 0; i < n; i++) begin
         d  = fixed ? (base + DW'(i)) : DW'($urandom);
         sb = (i == side_pos) || (rand_side && ($urandom_range(0, 3) == 0));
         mem[wr_ptr[9:0]] = {sb, d};
         exp_q.push_back({(i == n - 1), sb, d});
         wr_ptr++;
      end
   endtask

   task automatic start_block();
      @(posedge clk); #1;
      ppfifo_rdy = 1'b1;
      @(posedge clk); #1;
      ppfifo_rdy = 1'b0;
   endtask

   // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready
   task automatic stream(input int mode, input int budget);
      int k;
      k = 0;
      while (((exp_q.size() != 0) || act) && (k < budget)) begin
         @(posedge clk); #1;
         case (mode)
            0:       ready = 1'b1;
            1:       ready = ((k % 3) == 0);
            default: ready = 1'($urandom_range(0, 1));
         endcase
         k++;
      end
      check("stream_done", ((exp_q.size() == 0) && !act), 1);
      ready = 1'b1;
   endtask

   // Cycle-exact trace of one block with ready held high; cycle 0 is the
   // cycle in which rdy is sampled.
   task automatic timeline(input int n, input logic [DW-1:0] base);
      int last_act;
      load_block(n, -1, 1'b1, base, 1'b0);
      ready = 1'b1;
      last_act = (n == 0) ? 2 : n + 5;
      @(posedge clk); #1;
      ppfifo_rdy = 1'b1;
      for (int k = 0; k <= last_act + 1; k++) begin
         @(negedge clk);
         check("tl_act", act, (k >= 1) && (k <= last_act));
         check("tl_stb", stb, (k >= 2) && (k < 2 + n));
         check("tl_valid", valid, (k >= 4) && (k < 4 + n));
         if (valid) check("tl_last", last, (k == 3 + n));
         if (k == 0) begin
            @(posedge clk); #1;
            ppfifo_rdy = 1'b0;
         end
      end
      check("tl_drained", exp_q.size(), 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int k;
      int phase;
      bit seen_act;
      rst_n = 1'b0;
      ppfifo_rdy = 1'b0;
      ready = 1'b1;
      size = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_act", act, 0);
      check("rst_stb", stb, 0);
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
      check("rst_last", last, 0);
      check("rst_keep", keep, 4'hF);
      check("rst_state", dbg_state, 0);
      check("rst_state2", dbg_state2, 0);
      check("ppfifo_clk", ppfifo_clk, clk);
      check("ppfifo_clk2", ppfifo_clk2, clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_act", act, 0);

      // Size 4, ready high, data A0..A3
      timeline(4, 32'h0000_00A0);

      // Size 8, ready toggling 1,0,0
      load_block(8, -1, 1'b1, 32'd0, 1'b0);
      start_block();
      stream(1, 300);

      // Size 0: act pulses for WAIT and RELEASE only
      timeline(0, 32'd0);

      // Sideband bit on word 2 of a 6-word block
      load_block(6, 2, 1'b0, 32'd0, 1'b0);
      start_block();
      stream(0, 100);

      // Back-to-back blocks of 3 and 5 with rdy held high
      load_block(3, -1, 1'b0, 32'd0, 1'b1);
      ready = 1'b1;
      @(posedge clk); #1;
      ppfifo_rdy = 1'b1;
      k = 0;
      phase = 0;
      seen_act = 1'b0;
      while ((phase < 2) && (k < 200)) begin
         @(posedge clk); #1;
         k++;
         if (phase == 0) begin
            if (act) seen_act = 1'b1;
            else if (seen_act) begin
               load_block(5, -1, 1'b0, 32'd0, 1'b1);
               phase = 1;
            end
         end else if (act) begin
            ppfifo_rdy = 1'b0;
            phase = 2;
         end
      end
      ppfifo_rdy = 1'b0;
      check("b2b_gap", phase, 2);
      stream(0, 200);

      // Reset with two words buffered and ready low
      load_block(8, -1, 1'b0, 32'd0, 1'b1);
      ready = 1'b0;
      start_block();
      repeat (4) @(posedge clk);
      #1;
      check("pre_rst_valid", valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_act", act, 0);
      check("mid_rst_valid", valid, 0);
      check("mid_rst_stb", stb, 0);
      check("mid_rst_valid2", valid2, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready = 1'b1;
      load_block(5, -1, 1'b0, 32'd0, 1'b1);
      start_block();
      stream(2, 200);

      // Randomized blocks and backpressure
      for (int b = 0; b < 8; b++) begin
         load_block($urandom_range(0, 12), -1, 1'b0, 32'd0, 1'b1);
         start_block();
         stream(2, 400);
      end

      repeat (3) @(negedge clk);
      check("end_keep", keep, 4'hF);
      check("end_keep2", keep2, 4'hF);
      check("end_idle", act, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
